// File: rtl/heap_arbiter_pkg.sv
// Shared op encodings, reserved heap words and state types for heap_arbiter.
package heap_arbiter_pkg;

  localparam int DW = 16;

  typedef enum logic [1:0] {
    OP_ALLOC = 2'd0,
    OP_FREE  = 2'd1,
    OP_READ  = 2'd2,
    OP_WRITE = 2'd3
  } op_e;

  // Reserved heap words; addresses below 16'h0005 are never real cells.
  localparam logic [DW-1:0] UNDEF = 16'h0000;
  localparam logic [DW-1:0] NIL   = 16'h0001;
  localparam logic [DW-1:0] FALSE = 16'h0002;
  localparam logic [DW-1:0] TRUE  = 16'h0003;
  localparam logic [DW-1:0] UNIT  = 16'h0004;
  localparam logic [DW-1:0] ZERO  = 16'h8000;

  // Type tag lives in the MSB: 1 = immediate integer, 0 = pointer/reserved.
  localparam logic TAG_INT = 1'b1;
  localparam logic TAG_PTR = 1'b0;

  typedef enum logic [1:0] {
    RES_NONE = 2'd0,
    RES_ADDR = 2'd1,
    RES_DATA = 2'd2
  } res_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  function automatic logic is_pair(input logic [1:0] op_a, input logic [1:0] op_b);
    return ((op_a == OP_ALLOC) && (op_b == OP_FREE)) ||
           ((op_a == OP_FREE) && (op_b == OP_ALLOC));
  endfunction

endpackage

// File: rtl/heap_arbiter_arb_rr2.sv
// Two-way picker for non-paired contention: round-robin by default,
// strict req0 priority when HEAP_ARB_FIXED_PRIO_EN is defined.
module heap_arbiter_arb_rr2 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] gnt
);

`ifdef HEAP_ARB_FIXED_PRIO_EN
  logic unused_rr;
  assign unused_rr = ^{i_clk, i_rst, adv};

  always_comb begin
    gnt = 2'b00;
    if (req[0]) gnt = 2'b01;
    else if (req[1]) gnt = 2'b10;
  end
`else
  // fav_reg names the requester that wins the next tie.
  logic fav_reg, fav_next;

  always_comb begin
    gnt = req;
    if (&req) gnt = fav_reg ? 2'b10 : 2'b01;
    fav_next = fav_reg;
    if (adv && (|gnt)) fav_next = gnt[0];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) fav_reg <= 1'b0;
    else       fav_reg <= fav_next;
  end
`endif

endmodule

// File: rtl/heap_arbiter.sv
// Two-requester front end for the linked-memory heap; pairs ALLOC with FREE.
// Build option HEAP_ARB_FIXED_PRIO_EN selects strict req0 priority for ties.
module heap_arbiter
  import heap_arbiter_pkg::*;
#(
  parameter int DATA_SZ = 16,
  parameter int NREQ    = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [1:0]           i_req,
  input  logic [3:0]           i_op,
  input  logic [2*DATA_SZ-1:0] i_data,
  input  logic [2*DATA_SZ-1:0] i_addr,
  output logic [1:0]           o_gnt,
  output logic [1:0]           o_rvalid,
  output logic [DATA_SZ-1:0]   o_result,
  output logic                 o_err,
  output logic                 o_alloc,
  output logic [DATA_SZ-1:0]   o_data,
  output logic                 o_free,
  output logic [DATA_SZ-1:0]   o_faddr,
  output logic                 o_wr,
  output logic [DATA_SZ-1:0]   o_waddr,
  output logic [DATA_SZ-1:0]   o_wdata,
  output logic                 o_rd,
  output logic [DATA_SZ-1:0]   o_raddr,
  input  logic [DATA_SZ-1:0]   i_heap_addr,
  input  logic [DATA_SZ-1:0]   i_heap_rdata,
  input  logic                 i_heap_err
);

  state_e     state_reg, state_next;
  logic [1:0] pend_reg, pend_next;
  res_e       kind_reg, kind_next;

  logic       run, pair;
  logic [1:0] req_eff, arb_gnt, gnt;
  logic [1:0] op_w [2];
  logic [DATA_SZ-1:0] data_w [2];
  logic [DATA_SZ-1:0] addr_w [2];
  logic [1:0] sel_alloc, sel_free, sel_rd, sel_wr;
  logic [DATA_SZ-1:0] alloc_data_m [2];
  logic [DATA_SZ-1:0] free_addr_m [2];
  logic [DATA_SZ-1:0] rd_addr_m [2];
  logic [DATA_SZ-1:0] wr_addr_m [2];
  logic [DATA_SZ-1:0] wr_data_m [2];

  // Reset is treated as a halt for this cycle so nothing leaks out while it is held.
  assign run     = (state_reg == ST_RUN) && !i_rst;
  assign req_eff = i_req & {2{run}};
  assign pair    = (&req_eff) && is_pair(op_w[0], op_w[1]);

  heap_arbiter_arb_rr2 u_arb (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .req   (req_eff),
    .adv   (!pair),
    .gnt   (arb_gnt)
  );

  assign gnt   = pair ? 2'b11 : arb_gnt;
  assign o_gnt = gnt;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      assign op_w[gi]   = i_op[2*gi +: 2];
      assign data_w[gi] = i_data[DATA_SZ*gi +: DATA_SZ];
      assign addr_w[gi] = i_addr[DATA_SZ*gi +: DATA_SZ];

      assign sel_alloc[gi] = gnt[gi] && (op_w[gi] == OP_ALLOC);
      assign sel_free[gi]  = gnt[gi] && (op_w[gi] == OP_FREE);
      assign sel_rd[gi]    = gnt[gi] && (op_w[gi] == OP_READ);
      assign sel_wr[gi]    = gnt[gi] && (op_w[gi] == OP_WRITE);

      assign alloc_data_m[gi] = sel_alloc[gi] ? data_w[gi] : '0;
      assign free_addr_m[gi]  = sel_free[gi]  ? addr_w[gi] : '0;
      assign rd_addr_m[gi]    = sel_rd[gi]    ? addr_w[gi] : '0;
      assign wr_addr_m[gi]    = sel_wr[gi]    ? addr_w[gi] : '0;
      assign wr_data_m[gi]    = sel_wr[gi]    ? data_w[gi] : '0;
    end
  endgenerate

  // At most one granted op of each kind, so OR-merging the masked fields is a mux.
  assign o_alloc = |sel_alloc;
  assign o_data  = alloc_data_m[0] | alloc_data_m[1];
  assign o_free  = |sel_free;
  assign o_faddr = free_addr_m[0] | free_addr_m[1];
  assign o_rd    = |sel_rd;
  assign o_raddr = rd_addr_m[0] | rd_addr_m[1];
  assign o_wr    = |sel_wr;
  assign o_waddr = wr_addr_m[0] | wr_addr_m[1];
  assign o_wdata = wr_data_m[0] | wr_data_m[1];

  always_comb begin
    state_next = state_reg;
    pend_next  = gnt;
    kind_next  = RES_NONE;
    if (o_alloc)   kind_next = RES_ADDR;
    else if (o_rd) kind_next = RES_DATA;
    if ((state_reg == ST_RUN) && i_heap_err) state_next = ST_HALT;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= ST_RUN;
      pend_reg  <= 2'b00;
      kind_reg  <= RES_NONE;
    end else begin
      state_reg <= state_next;
      pend_reg  <= pend_next;
      kind_reg  <= kind_next;
    end
  end

  // A paired grant completes both owners; the FREE owner ignores o_result.
  assign o_rvalid = pend_reg & {2{run && !i_heap_err}};
  assign o_err    = (state_reg == ST_HALT);

  always_comb begin
    o_result = UNDEF;
    if (run) begin
      case (kind_reg)
        RES_ADDR: o_result = i_heap_addr;
        RES_DATA: o_result = i_heap_rdata;
        default:  o_result = UNDEF;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      assert (NREQ == 2 && DATA_SZ == DW);
      assert (!((o_alloc || o_free) && (o_rd || o_wr)));
      assert (!(o_rd && o_wr));
    end
  end

endmodule

// File: tb/tb_heap_arbiter.sv
// Randomised self-checking bench for heap_arbiter against a cycle-level model.
module tb_heap_arbiter;
  import heap_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [3:0]  op;
  logic [31:0] data, addr;
  logic [1:0]  gnt, rvalid;
  logic [15:0] result;
  logic        err;
  logic        alloc, free, wr, rd;
  logic [15:0] odata, faddr, waddr, wdata, raddr;
  logic [15:0] heap_addr, heap_rdata;
  logic        heap_err;

  always #5 clk = ~clk;

  heap_arbiter dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_op(op), .i_data(data), .i_addr(addr),
    .o_gnt(gnt), .o_rvalid(rvalid), .o_result(result), .o_err(err),
    .o_alloc(alloc), .o_data(odata), .o_free(free), .o_faddr(faddr),
    .o_wr(wr), .o_waddr(waddr), .o_wdata(wdata), .o_rd(rd), .o_raddr(raddr),
    .i_heap_addr(heap_addr), .i_heap_rdata(heap_rdata), .i_heap_err(heap_err)
  );

  wire [83:0] heap_vec = {alloc, odata, free, faddr, wr, waddr, wdata, rd, raddr};

  int n_chk = 0;
  int n_fail = 0;

  // Model state: who wins the next tie, outstanding owners, result kind (0 none, 1 addr, 2 data).
  logic       fav;
  logic       halted;
  logic [1:0] prev_gnt;
  int         prev_kind;

  logic [1:0]  e_gnt, e_rvalid;
  logic [15:0] e_result;
  logic        e_err;
  logic [83:0] e_heap;

  task automatic model_reset();
    fav = 1'b0; halted = 1'b0; prev_gnt = 2'b00; prev_kind = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = 2'b00; heap_err = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Drives one cycle and predicts every DUT output for it; returns #1 after the negedge.
  task automatic do_cycle(input logic [1:0] r, input logic [1:0] o0, input logic [1:0] o1,
                          input logic [15:0] d0, input logic [15:0] d1,
                          input logic [15:0] a0, input logic [15:0] a1,
                          input logic [15:0] ha, input logic [15:0] hr, input logic he);
    logic [1:0]  ops [2];
    logic [15:0] ds [2];
    logic [15:0] as [2];
    logic        pairx, ea, ef, ew, er;
    logic [15:0] ed, efa, ewa, ewd, era;
    int          kind;
    @(negedge clk);
    req = r; op = {o1, o0}; data = {d1, d0}; addr = {a1, a0};
    heap_addr = ha; heap_rdata = hr; heap_err = he;
    ops[0] = o0; ops[1] = o1; ds[0] = d0; ds[1] = d1; as[0] = a0; as[1] = a1;

    e_err    = halted;
    e_rvalid = (halted || he) ? 2'b00 : prev_gnt;
    e_result = (prev_kind == 1) ? ha : (prev_kind == 2) ? hr : 16'h0000;

    pairx = (r == 2'b11) && (((o0 == OP_ALLOC) && (o1 == OP_FREE)) ||
                             ((o0 == OP_FREE) && (o1 == OP_ALLOC)));
    if (halted)          e_gnt = 2'b00;
    else if (pairx)      e_gnt = 2'b11;
    else if (r == 2'b11) e_gnt = fav ? 2'b10 : 2'b01;
    else                 e_gnt = r;

    ea = 0; ef = 0; ew = 0; er = 0; ed = 0; efa = 0; ewa = 0; ewd = 0; era = 0;
    for (int i = 0; i < 2; i++) begin
      if (e_gnt[i]) begin
        case (ops[i])
          2'd0: begin ea = 1; ed = ds[i]; end
          2'd1: begin ef = 1; efa = as[i]; end
          2'd2: begin er = 1; era = as[i]; end
          default: begin ew = 1; ewa = as[i]; ewd = ds[i]; end
        endcase
      end
    end
    e_heap = {ea, ed, ef, efa, ew, ewa, ewd, er, era};
    kind = ea ? 1 : (er ? 2 : 0);

    prev_gnt  = e_gnt;
    prev_kind = kind;
`ifndef HEAP_ARB_FIXED_PRIO_EN
    if (!pairx && (e_gnt != 2'b00)) fav = (e_gnt == 2'b01);
`endif
    if (he) halted = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; req = 2'b11; op = {OP_READ, OP_READ}; data = '0; addr = '0;
    heap_addr = 16'h1234; heap_rdata = 16'h5678; heap_err = 1'b0;
    #1;
    n_chk++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b expected 00", gnt); end
    n_chk++; if (heap_vec !== 84'd0) begin n_fail++; $display("FAIL reset_heap: got %h expected 0", heap_vec); end
    @(negedge clk);
    rst = 1'b0; req = 2'b00;
    #1;
    n_chk++; if (rvalid !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid: got %b expected 00", rvalid); end
    n_chk++; if (result !== 16'h0000) begin n_fail++; $display("FAIL reset_result: got %h expected 0000", result); end
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
    model_reset();
  endtask

  task automatic test_single_alloc();
    do_reset();
    do_cycle(2'b01, OP_ALLOC, OP_READ, 16'h8005, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
    n_chk++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL alloc_gnt: got %b expected 01", gnt); end
    n_chk++; if (heap_vec !== e_heap) begin n_fail++; $display("FAIL alloc_port: got %h expected %h", heap_vec, e_heap); end
    n_chk++; if (!(alloc === 1'b1 && odata === 16'h8005)) begin n_fail++; $display("FAIL alloc_data: got %b/%h expected 1/8005", alloc, odata); end
    do_cycle(2'b00, OP_ALLOC, OP_ALLOC, 16'h0, 16'h0, 16'h0, 16'h0, 16'h50FE, 16'hAAAA, 1'b0);
    n_chk++; if (rvalid !== 2'b01) begin n_fail++; $display("FAIL alloc_rvalid: got %b expected 01", rvalid); end
    n_chk++; if (result !== 16'h50FE) begin n_fail++; $display("FAIL alloc_result: got %h expected 50fe", result); end
    $display("single alloc: gnt=%b result=%h", gnt, result);
  endtask

  task automatic test_rr_reads();
    logic [1:0] lit;
    do_reset();
    for (int k = 0; k < 7; k++) begin
      do_cycle((k < 6) ? 2'b11 : 2'b00, OP_READ, OP_READ, 16'h0, 16'h0,
               16'h0100 + 16'(k), 16'h0200 + 16'(k), 16'($urandom), 16'($urandom), 1'b0);
`ifdef HEAP_ARB_FIXED_PRIO_EN
      lit = (k < 6) ? 2'b01 : 2'b00;
`else
      lit = (k >= 6) ? 2'b00 : ((k % 2) == 1) ? 2'b10 : 2'b01;
`endif
      n_chk++; if (gnt !== lit) begin n_fail++; $display("FAIL rr_gnt[%0d]: got %b expected %b", k, gnt, lit); end
      n_chk++; if (rvalid !== e_rvalid) begin n_fail++; $display("FAIL rr_rvalid[%0d]: got %b expected %b", k, rvalid, e_rvalid); end
      n_chk++; if (result !== e_result) begin n_fail++; $display("FAIL rr_result[%0d]: got %h expected %h", k, result, e_result); end
      $display("rr read %0d: gnt=%b rvalid=%b raddr=%h", k, gnt, rvalid, raddr);
    end
  endtask

  task automatic test_pair();
    do_reset();
    do_cycle(2'b11, OP_ALLOC, OP_FREE, 16'h8007, 16'h0, 16'h0, 16'h5010, 16'h0, 16'h0, 1'b0);
    n_chk++; if (gnt !== 2'b11) begin n_fail++; $display("FAIL pair_gnt: got %b expected 11", gnt); end
    n_chk++; if (!(alloc === 1'b1 && free === 1'b1 && faddr === 16'h5010)) begin
      n_fail++; $display("FAIL pair_port: got alloc=%b free=%b faddr=%h expected 1 1 5010", alloc, free, faddr); end
    n_chk++; if (heap_vec !== e_heap) begin n_fail++; $display("FAIL pair_vec: got %h expected %h", heap_vec, e_heap); end
    do_cycle(2'b11, OP_FREE, OP_ALLOC, 16'h0, 16'h8009, 16'h5020, 16'h0, 16'h5010, 16'h0, 1'b0);
    n_chk++; if (rvalid !== 2'b11) begin n_fail++; $display("FAIL pair_rvalid: got %b expected 11", rvalid); end
    n_chk++; if (result !== 16'h5010) begin n_fail++; $display("FAIL pair_result: got %h expected 5010", result); end
    n_chk++; if (gnt !== 2'b11 || faddr !== 16'h5020 || odata !== 16'h8009) begin
      n_fail++; $display("FAIL pair_swap: got gnt=%b faddr=%h data=%h expected 11 5020 8009", gnt, faddr, odata); end
    $display("pair: gnt=%b faddr=%h", gnt, faddr);
  endtask

  task automatic test_random();
    int bad = 0;
    for (int k = 0; k < 1000; k++) begin
      do_cycle(2'($urandom), 2'($urandom), 2'($urandom), 16'($urandom), 16'($urandom),
               16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'b0);
      n_chk++; if (gnt !== e_gnt) begin n_fail++; bad++; $display("FAIL rand_gnt[%0d]: got %b expected %b", k, gnt, e_gnt); end
      n_chk++; if (heap_vec !== e_heap) begin n_fail++; bad++; $display("FAIL rand_port[%0d]: got %h expected %h", k, heap_vec, e_heap); end
      n_chk++; if (rvalid !== e_rvalid) begin n_fail++; bad++; $display("FAIL rand_rvalid[%0d]: got %b expected %b", k, rvalid, e_rvalid); end
      n_chk++; if (result !== e_result) begin n_fail++; bad++; $display("FAIL rand_result[%0d]: got %h expected %h", k, result, e_result); end
      n_chk++; if (((alloc | free) && (rd | wr)) || (rd && wr)) begin
        n_fail++; bad++; $display("FAIL rand_mixed[%0d]: got a%b f%b r%b w%b expected no mix", k, alloc, free, rd, wr); end
    end
    $display("random: 1000 cycles, %0d mismatching checks", bad);
  endtask

  task automatic test_error();
    do_reset();
    do_cycle(2'b01, OP_READ, OP_READ, 16'h0, 16'h0, 16'h0030, 16'h0, 16'h0, 16'h0, 1'b0);
    do_cycle(2'b00, OP_READ, OP_READ, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'hBEEF, 1'b1);
    n_chk++; if (rvalid !== 2'b00) begin n_fail++; $display("FAIL err_rvalid: got %b expected 00", rvalid); end
    for (int k = 0; k < 2; k++) begin
      do_cycle(2'b11, OP_READ, OP_WRITE, 16'h0, 16'h1, 16'h0031, 16'h0032, 16'h0, 16'h0, 1'b0);
      n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_flag[%0d]: got %b expected 1", k, err); end
      n_chk++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL err_gnt[%0d]: got %b expected 00", k, gnt); end
      n_chk++; if (heap_vec !== 84'd0) begin n_fail++; $display("FAIL err_port[%0d]: got %h expected 0", k, heap_vec); end
      n_chk++; if (rvalid !== 2'b00) begin n_fail++; $display("FAIL err_halt_rvalid[%0d]: got %b expected 00", k, rvalid); end
    end
    do_reset();
    do_cycle(2'b10, OP_READ, OP_WRITE, 16'h0, 16'h7, 16'h0, 16'h0040, 16'h0, 16'h0, 1'b0);
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b expected 0", err); end
    n_chk++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL err_resume: got %b expected 10", gnt); end
    $display("error: halted then resumed, gnt=%b", gnt);
  endtask

  task automatic test_reset_mid();
    do_reset();
    do_cycle(2'b01, OP_READ, OP_READ, 16'h0, 16'h0, 16'h0050, 16'h0, 16'h0, 16'h0, 1'b0);
    @(negedge clk);
    rst = 1'b1; req = 2'b00; heap_rdata = 16'hCAFE;
    #1;
    n_chk++; if (rvalid !== 2'b00) begin n_fail++; $display("FAIL midrst_rvalid: got %b expected 00", rvalid); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_chk++; if (rvalid !== 2'b00) begin n_fail++; $display("FAIL midrst_after: got %b expected 00", rvalid); end
    model_reset();
    $display("reset mid-op: rvalid=%b", rvalid);
  endtask

  task automatic test_back_to_back();
    int g0 = 0;
    int exp0;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      do_cycle(2'b11, OP_WRITE, OP_WRITE, 16'h1000 + 16'(k), 16'h2000 + 16'(k),
               16'h0060, 16'h0070, 16'h0, 16'h0, 1'b0);
      n_chk++; if (gnt !== e_gnt) begin n_fail++; $display("FAIL b2b_gnt[%0d]: got %b expected %b", k, gnt, e_gnt); end
      n_chk++; if (heap_vec !== e_heap) begin n_fail++; $display("FAIL b2b_port[%0d]: got %h expected %h", k, heap_vec, e_heap); end
      if (gnt === 2'b01) g0++;
      $display("write %0d: gnt=%b waddr=%h", k, gnt, waddr);
    end
`ifdef HEAP_ARB_FIXED_PRIO_EN
    exp0 = 4;
`else
    exp0 = 2;
`endif
    n_chk++; if (g0 != exp0) begin n_fail++; $display("FAIL b2b_count: got %0d expected %0d", g0, exp0); end
  endtask

  initial begin
    rst = 1'b1; req = 2'b00; op = '0; data = '0; addr = '0;
    heap_addr = '0; heap_rdata = '0; heap_err = 1'b0;
    model_reset();
    test_reset();
    test_single_alloc();
    test_rr_reads();
    test_pair();
    test_random();
    test_error();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
